// File: rtl/atm_pkg.sv
// Shared definitions for the PIN keypad front end: key codes, FSM state encoding
// and the shift-register command set.
package atm_pkg;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_CLR       = 4'hA;
    localparam logic [3:0] KEY_BS        = 4'hB;
    localparam logic [3:0] KEY_ENT       = 4'hC;
    localparam logic [3:0] KEY_CAN       = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_SUBMIT    = 3'd2,
        S_WAIT_RES  = 3'd3,
        S_DONE      = 3'd4,
        S_LOCKED    = 3'd5,
        S_IDLE_WAIT = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SR_NOP  = 2'd0,
        SR_PUSH = 2'd1,
        SR_POP  = 2'd2,
        SR_CLR  = 2'd3
    } sr_op_t;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= KEY_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/pin_shift_reg.sv
// Packed BCD digit store with digit count; executes one push/pop/clear command per cycle.
module pin_shift_reg
    import atm_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PSW_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  sr_op_t                       op_i,
    input  logic [3:0]                   digit_i,
    output logic [PSW_WIDTH-1:0]         psw_o,
    output logic [$clog2(DIGITS+1)-1:0]  count_o
);

    localparam int CW = $clog2(DIGITS + 1);

    logic [PSW_WIDTH-1:0] psw_q, psw_d;
    logic [CW-1:0]        count_q, count_d;

    // Next-state decode of the stored word and count
    always_comb begin
        psw_d   = psw_q;
        count_d = count_q;
        case (op_i)
            SR_PUSH: begin
                psw_d   = {psw_q[PSW_WIDTH-5:0], digit_i};
                count_d = count_q + CW'(1);
            end
            SR_POP: begin
                psw_d   = psw_q >> 4;
                count_d = count_q - CW'(1);
            end
            SR_CLR: begin
                psw_d   = '0;
                count_d = '0;
            end
            default: begin
                psw_d   = psw_q;
                count_d = count_q;
            end
        endcase
    end

    // Word and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            psw_q   <= '0;
            count_q <= '0;
        end else begin
            psw_q   <= psw_d;
            count_q <= count_d;
        end
    end

    assign psw_o   = psw_q;
    assign count_o = count_q;

endmodule

// File: rtl/pin_entry.sv
// Keypad PIN collector: packs digits, submits the word, tracks rejections and card lock.
// Optional inactivity timeout in COLLECT is enabled by defining PIN_ENTRY_TIMEOUT_EN.
module pin_entry
    import atm_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int PSW_WIDTH   = 16,
    parameter int RETRY_MAX   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         card_present,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    input  logic                         psw_ok,
    input  logic                         psw_bad,
    output logic [PSW_WIDTH-1:0]         password_input,
    output logic                         psw_submit,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         key_error,
    output logic [1:0]                   attempts,
    output logic                         card_lock,
    output logic                         busy
);

    localparam int            CW         = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(DIGITS);
    localparam logic [1:0]    RETRY_LAST = 2'(RETRY_MAX - 1);

    if (PSW_WIDTH != 4 * DIGITS) begin : g_bad_width
        $error("pin_entry: PSW_WIDTH must equal 4*DIGITS");
    end
    if (RETRY_MAX < 1 || RETRY_MAX > 3) begin : g_bad_retry
        $error("pin_entry: RETRY_MAX must fit the 2-bit attempts counter");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("pin_entry: TIMEOUT_CYC must be at least 1");
    end

    state_t     state_q, state_d;
    sr_op_t     sr_op_s;
    logic       key_error_q, key_error_d;
    logic       psw_submit_q, psw_submit_d;
    logic [1:0] attempts_q, attempts_d;
    logic       card_lock_q, card_lock_d;
    logic       busy_q, busy_d;
    logic       timeout_s;

    pin_shift_reg #(
        .DIGITS    (DIGITS),
        .PSW_WIDTH (PSW_WIDTH)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .op_i    (sr_op_s),
        .digit_i (key_code),
        .psw_o   (password_input),
        .count_o (digit_count)
    );

`ifdef PIN_ENTRY_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] timer_q, timer_d;

    assign timeout_s = (timer_q == TO_LAST);

    // Inactivity counter: restarts on any key or on entry to COLLECT, runs only in COLLECT
    always_comb begin
        if (key_valid) begin
            timer_d = '0;
        end else if (state_d == S_COLLECT && state_q != S_COLLECT) begin
            timer_d = '0;
        end else if (state_q == S_COLLECT && !timeout_s) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Inactivity counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // FSM next-state and output decode; card removal outranks verdicts, verdicts outrank keys
    always_comb begin
        state_d      = state_q;
        sr_op_s      = SR_NOP;
        key_error_d  = 1'b0;
        psw_submit_d = 1'b0;
        attempts_d   = attempts_q;
        case (state_q)
            S_IDLE: begin
                if (card_present) begin
                    sr_op_s    = SR_CLR;
                    attempts_d = 2'd0;
                    state_d    = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (!card_present) begin
                    sr_op_s    = SR_CLR;
                    attempts_d = 2'd0;
                    state_d    = S_IDLE;
                end else if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (digit_count < CNT_FULL) begin
                            sr_op_s = SR_PUSH;
                        end else begin
                            key_error_d = 1'b1;
                        end
                    end else begin
                        case (key_code)
                            KEY_CLR: sr_op_s = SR_CLR;
                            KEY_BS: begin
                                if (digit_count != '0) begin
                                    sr_op_s = SR_POP;
                                end else begin
                                    key_error_d = 1'b1;
                                end
                            end
                            KEY_ENT: begin
                                if (digit_count == CNT_FULL) begin
                                    psw_submit_d = 1'b1;
                                    state_d      = S_SUBMIT;
                                end else begin
                                    key_error_d = 1'b1;
                                end
                            end
                            KEY_CAN: state_d = S_IDLE_WAIT;
                            default: key_error_d = 1'b1;
                        endcase
                    end
                end else if (timeout_s) begin
                    key_error_d = 1'b1;
                    sr_op_s     = SR_CLR;
                    state_d     = S_IDLE_WAIT;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_SUBMIT: begin
                if (!card_present) begin
                    sr_op_s    = SR_CLR;
                    attempts_d = 2'd0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (!card_present) begin
                    sr_op_s    = SR_CLR;
                    attempts_d = 2'd0;
                    state_d    = S_IDLE;
                end else if (psw_bad) begin
                    attempts_d = attempts_q + 2'd1;
                    if (attempts_q == RETRY_LAST) begin
                        state_d = S_LOCKED;
                    end else begin
                        sr_op_s = SR_CLR;
                        state_d = S_COLLECT;
                    end
                end else if (psw_ok) begin
                    attempts_d = 2'd0;
                    sr_op_s    = SR_CLR;
                    state_d    = S_DONE;
                end else if (key_valid) begin
                    key_error_d = 1'b1;
                end else begin
                    state_d = S_WAIT_RES;
                end
            end
            S_DONE: begin
                if (!card_present) begin
                    sr_op_s    = SR_CLR;
                    attempts_d = 2'd0;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_LOCKED: state_d = S_LOCKED;
            S_IDLE_WAIT: begin
                if (!card_present) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE_WAIT;
                end
            end
            default: begin
                sr_op_s = SR_CLR;
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d == S_WAIT_RES);
        card_lock_d = (state_d == S_LOCKED);
    end

    // FSM state and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_error_q  <= 1'b0;
            psw_submit_q <= 1'b0;
            attempts_q   <= 2'd0;
            card_lock_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_error_q  <= key_error_d;
            psw_submit_q <= psw_submit_d;
            attempts_q   <= attempts_d;
            card_lock_q  <= card_lock_d;
            busy_q       <= busy_d;
        end
    end

    assign key_error  = key_error_q;
    assign psw_submit = psw_submit_q;
    assign attempts   = attempts_q;
    assign card_lock  = card_lock_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry: a queue-based reference model is checked every cycle,
// with literal expectations pinning key points of the test plan.
module tb_pin_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_present = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        psw_ok = 1'b0;
    logic        psw_bad = 1'b0;
    logic [15:0] password_input;
    logic        psw_submit;
    logic [2:0]  digit_count;
    logic        key_error;
    logic [1:0]  attempts;
    logic        card_lock;
    logic        busy;

    pin_entry #(
        .DIGITS      (4),
        .PSW_WIDTH   (16),
        .RETRY_MAX   (3),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .card_present   (card_present),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .psw_ok         (psw_ok),
        .psw_bad        (psw_bad),
        .password_input (password_input),
        .psw_submit     (psw_submit),
        .digit_count    (digit_count),
        .key_error      (key_error),
        .attempts       (attempts),
        .card_lock      (card_lock),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_COLLECT = 1, M_SUBMIT = 2, M_WAIT = 3,
                   M_DONE = 4, M_LOCKED = 5, M_IDLE_WAIT = 6;
    localparam int TO = 20;

    int n_pass = 0;
    int n_checks = 0;
    int mq[$];
    int m_st = M_IDLE;
    int m_att = 0;
    int m_idle = 0;
    bit m_kerr = 1'b0;
    bit m_sub = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int pw_of();
        int v = 0;
        foreach (mq[i]) v = v * 16 + mq[i];
        return v;
    endfunction

    task automatic card_gone();
        mq.delete();
        m_att = 0;
        m_st = M_IDLE;
    endtask

    // Reference behaviour for one clock edge, driven by the inputs currently applied
    task automatic model_step();
        m_kerr = 1'b0;
        m_sub = 1'b0;
        if (rst) begin
            mq.delete(); m_att = 0; m_st = M_IDLE; m_idle = 0;
        end else begin
            case (m_st)
                M_IDLE: if (card_present) begin
                    mq.delete(); m_att = 0; m_st = M_COLLECT; m_idle = 0;
                end
                M_COLLECT: begin
                    if (!card_present) card_gone();
                    else if (key_valid) begin
                        m_idle = 0;
                        if (key_code <= 4'd9) begin
                            if (mq.size() < 4) mq.push_back(int'(key_code));
                            else m_kerr = 1'b1;
                        end else if (key_code == 4'hA) mq.delete();
                        else if (key_code == 4'hB) begin
                            if (mq.size() > 0) void'(mq.pop_back());
                            else m_kerr = 1'b1;
                        end else if (key_code == 4'hC) begin
                            if (mq.size() == 4) begin m_st = M_SUBMIT; m_sub = 1'b1; end
                            else m_kerr = 1'b1;
                        end else if (key_code == 4'hD) m_st = M_IDLE_WAIT;
                        else m_kerr = 1'b1;
                    end else begin
`ifdef PIN_ENTRY_TIMEOUT_EN
                        m_idle++;
                        if (m_idle == TO) begin
                            m_kerr = 1'b1; mq.delete(); m_st = M_IDLE_WAIT;
                        end
`endif
                    end
                end
                M_SUBMIT: if (!card_present) card_gone(); else m_st = M_WAIT;
                M_WAIT: begin
                    if (!card_present) card_gone();
                    else if (psw_bad) begin
                        m_att++;
                        if (m_att >= 3) m_st = M_LOCKED;
                        else begin mq.delete(); m_st = M_COLLECT; m_idle = 0; end
                    end else if (psw_ok) begin
                        m_att = 0; mq.delete(); m_st = M_DONE;
                    end else if (key_valid) m_kerr = 1'b1;
                end
                M_DONE: if (!card_present) card_gone();
                M_IDLE_WAIT: if (!card_present) m_st = M_IDLE;
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("password_input", password_input, pw_of());
        chk("digit_count", digit_count, mq.size());
        chk("key_error", key_error, m_kerr);
        chk("psw_submit", psw_submit, m_sub);
        chk("attempts", attempts, m_att);
        chk("card_lock", card_lock, m_st == M_LOCKED);
        chk("busy", busy, m_st == M_WAIT);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code = c;
        cycle();
        key_valid = 1'b0;
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        for (int i = 3; i >= 0; i--) key(pin[i*4 +: 4]);
        key(4'hC);
    endtask

    task automatic verdict(input logic ok, input logic bad);
        psw_ok = ok;
        psw_bad = bad;
        cycle();
        psw_ok = 1'b0;
        psw_bad = 1'b0;
    endtask

    initial begin
        idle(2);
        chk("lit_reset_pw", password_input, 32'h0);
        chk("lit_reset_lock", card_lock, 32'h0);
        rst = 1'b0;
        card_present = 1'b1;
        idle(1);

        enter_pin(16'h1234);
        chk("lit_submit", psw_submit, 32'h1);
        chk("lit_pw_1234", password_input, 32'h1234);
        chk("lit_cnt4", digit_count, 32'h4);
        idle(1);
        chk("lit_busy", busy, 32'h1);
        verdict(1'b0, 1'b1);
        chk("lit_att1", attempts, 32'h1);

        key(4'h5); key(4'h6); key(4'hB); key(4'h7); key(4'h8); key(4'h9);
        chk("lit_pw_5789", password_input, 32'h5789);
        key(4'h1);
        chk("lit_5th_digit_err", key_error, 32'h1);
        chk("lit_5th_digit_pw", password_input, 32'h5789);
        key(4'hC);
        chk("lit_submit_5789", psw_submit, 32'h1);
        idle(1);
        verdict(1'b0, 1'b1);
        chk("lit_att2", attempts, 32'h2);

        key(4'h1); key(4'h2); key(4'hC);
        chk("lit_short_enter_err", key_error, 32'h1);
        chk("lit_short_enter_nosub", psw_submit, 32'h0);
        key(4'hA);
        chk("lit_clr_cnt", digit_count, 32'h0);
        chk("lit_clr_pw", password_input, 32'h0);
        key(4'hB);
        chk("lit_bs_empty_err", key_error, 32'h1);
        key(4'hE);
        idle(1);

        enter_pin(16'h9876);
        idle(1);
        key(4'h3);
        chk("lit_key_in_wait_err", key_error, 32'h1);
        key_valid = 1'b1; key_code = 4'h1;
        verdict(1'b0, 1'b1);
        key_valid = 1'b0;
        chk("lit_lock", card_lock, 32'h1);
        chk("lit_verdict_wins", key_error, 32'h0);
        card_present = 1'b0;
        idle(3);
        chk("lit_lock_held", card_lock, 32'h1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("lit_rst_unlock", card_lock, 32'h0);

        card_present = 1'b1;
        idle(1);
        enter_pin(16'h1111);
        idle(1);
        verdict(1'b0, 1'b1);
        key(4'h3); key(4'h1); key(4'h4);
        card_present = 1'b0;
        idle(1);
        chk("lit_remove_pw", password_input, 32'h0);
        chk("lit_remove_att", attempts, 32'h0);

        card_present = 1'b1;
        idle(1);
        enter_pin(16'h2222);
        idle(1);
        verdict(1'b1, 1'b1);
        chk("lit_both_verdicts", attempts, 32'h1);
        enter_pin(16'h4321);
        idle(1);
        verdict(1'b1, 1'b0);
        chk("lit_ok_att", attempts, 32'h0);
        key(4'h5);
        card_present = 1'b0;
        idle(1);

        card_present = 1'b1;
        idle(1);
        key(4'h5); key(4'hD);
        idle(2);
        key(4'h7);
        card_present = 1'b0;
        idle(1);
        card_present = 1'b1;
        idle(1);

        idle(25);
        key(4'h8);
`ifdef PIN_ENTRY_TIMEOUT_EN
        chk("lit_timeout_cleared", digit_count, 32'h0);
`else
        chk("lit_no_timeout", digit_count, 32'h1);
`endif
        card_present = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pin_entry.md
Name: pin_entry

Overview:
- Keypad front end that sits directly upstream of the card-handling stage.
- Collects BCD digit keystrokes while a card is present and packs them into the password_input word.
- Presents the word with a one-cycle submit strobe, then waits for the accept/reject verdict.
- Counts rejected attempts and raises a card lock after RETRY_MAX consecutive rejections.

Parameters:
- DIGITS, 4, number of PIN digits; the password word is 4*DIGITS bits.
- PSW_WIDTH, 16, password word width; must equal 4*DIGITS.
- RETRY_MAX, 3, consecutive rejections that trigger card_lock.
- TIMEOUT_CYC, 1000, inactivity limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- card_present  in  1  level; high while a card is inserted.
- key_valid  in  1  one-cycle strobe qualifying key_code.
- key_code  in  4  0-9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD cancel; 0xE/0xF illegal.
- psw_ok  in  1  one-cycle pulse: card handling accepted the submitted PIN.
- psw_bad  in  1  one-cycle pulse: card handling rejected the submitted PIN.
- password_input  out  PSW_WIDTH  packed BCD PIN; first digit in the MS nibble.
- psw_submit  out  1  one-cycle pulse; password_input is valid in that cycle and stays stable until the verdict.
- digit_count  out  $clog2(DIGITS+1)  digits entered so far, for display.
- key_error  out  1  one-cycle pulse on an illegal or rejected key.
- attempts  out  2  consecutive rejections so far.
- card_lock  out  1  level; the card must be retained.
- busy  out  1  high while in WAIT_RES.

Behaviour:
- Reset: all outputs 0, state IDLE, shift register 0.
- Outputs are registered. Each response appears one cycle after the triggering input.
- IDLE:
  - Keys are ignored.
  - When card_present=1: clear register, count and attempts, then go to COLLECT.
- COLLECT:
  - Digit with count<DIGITS: reg <= {reg[PSW_WIDTH-5:0], digit}; count++.
  - Digit with count==DIGITS: key_error pulse; register unchanged.
  - Backspace: reg <= reg>>4; count--. At count 0, key_error pulse instead.
  - Clear: reg=0, count=0.
  - Enter with count==DIGITS: go to SUBMIT. Enter with count<DIGITS: key_error pulse; stay.
  - Cancel: go to IDLE_WAIT.
  - Codes 0xE/0xF: key_error pulse.
- SUBMIT: psw_submit=1 for exactly one cycle, then go to WAIT_RES.
- WAIT_RES:
  - Keys are ignored; a key during WAIT_RES gives a key_error pulse.
  - psw_ok: attempts=0, register cleared, go to DONE.
  - psw_bad: attempts++. If attempts reaches RETRY_MAX, card_lock=1 and go to LOCKED. Otherwise clear register and count, go to COLLECT.
  - psw_ok and psw_bad in the same cycle: treated as psw_bad.
- DONE: remains until card_present=0, then go to IDLE.
- LOCKED: card_lock held high; leaves only on rst.
- IDLE_WAIT: waits for card_present=0, then goes to IDLE.
- Card removal: card_present falling in COLLECT/SUBMIT/WAIT_RES/DONE gives IDLE next cycle; register, count and attempts are cleared. LOCKED ignores card removal.
- Key strobe coincident with the verdict: the verdict wins; the key is dropped without key_error.

Optional Feature:
- Macro: PIN_ENTRY_TIMEOUT_EN.
- With the macro defined:
  - An inactivity counter is reset by every key_valid and by entry into COLLECT.
  - In COLLECT, reaching TIMEOUT_CYC cycles with no key gives key_error pulse, clears the entry and goes to IDLE_WAIT.
  - The counter is frozen in all other states.
- Without the macro: no counter; COLLECT waits indefinitely.

Decomposition:
- Shared package (atm_pkg): key code constants KEY_CLR/KEY_BS/KEY_ENT/KEY_CAN and the state enum encoding.
- One natural sub-module: pin_shift_reg (packing, backspace, clear, count).
- FSM, attempt counter and timeout stay in pin_entry.

Test Plan:
- Insert card; keys 1,2,3,4, Enter -> psw_submit pulse with password_input=16'h1234, digit_count=4, busy=1.
- Keys 5,6,Backspace,7,8,9, Enter -> submit of 16'h5789; a 5th digit before Enter gives key_error and the word is unchanged.
- Enter after 2 digits -> key_error pulse, no submit; then Clear -> digit_count=0, password_input=0.
- Three psw_bad verdicts -> attempts goes 1,2 then card_lock=1; removing the card keeps LOCKED; rst clears it.
- card_present drops mid-entry after 3 digits -> IDLE next cycle, password_input=0, attempts=0; psw_ok and psw_bad together -> counted as a rejection.
- PIN_ENTRY_TIMEOUT_EN with TIMEOUT_CYC=20: no key for 20 cycles in COLLECT -> key_error pulse, entry cleared, IDLE_WAIT.
